// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: refills one cache line from a byte-wide RAM and hands it back as a single pulse.
module icache_fill_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int BLOCK_BYTES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     req,
    input  logic [ADDR_W-1:0]        block_addr,
    output logic                     fill_valid,
    output logic [8*BLOCK_BYTES-1:0] fill_data,
    output logic                     busy,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_wr,
    input  logic [7:0]               mem_din
);
    localparam int OW = $clog2(BLOCK_BYTES);
    localparam int CW = OW + 1;
    localparam int LW = 8 * BLOCK_BYTES;

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base, aligned;
    logic [CW-1:0]     icnt, rcnt;
    logic              pend, cap, last;
    logic [LW-1:0]     line;

    assign aligned    = block_addr & ~ADDR_W'(BLOCK_BYTES - 1);
    assign busy       = state != IDLE;
    assign fill_valid = state == DONE;
    assign mem_wr     = 1'b0;

    // pend marks that the previous READ cycle issued an address, so mem_din now holds its byte
    always_comb begin
        cap      = state == READ && req && pend;
        last     = cap && rcnt == CW'(BLOCK_BYTES - 1);
        state_nx = state;
        case (state)
            IDLE:    state_nx = req ? READ : IDLE;
            READ:    state_nx = !req ? IDLE : (last ? DONE : READ);
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else if (rdy)
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            base      <= '0;
            mem_a     <= '0;
            icnt      <= '0;
            rcnt      <= '0;
            pend      <= 1'b0;
            line      <= '0;
            fill_data <= '0;
        end else if (rdy) begin
            if (state == IDLE && req) begin
                base  <= aligned;
                mem_a <= aligned;
                icnt  <= CW'(1);
                rcnt  <= '0;
                pend  <= 1'b0;
                line  <= '0;
            end else if (state == READ && req) begin
                pend <= 1'b1;
                if (icnt < CW'(BLOCK_BYTES)) begin
                    mem_a <= base + ADDR_W'(icnt);
                    icnt  <= icnt + CW'(1);
                end
                if (cap) begin
                    line[{rcnt[OW-1:0], 3'b000} +: 8] <= mem_din;
                    rcnt <= rcnt + CW'(1);
                end
                // the final byte goes straight into fill_data so the line is ready in DONE
                if (last)
                    fill_data <= {mem_din, line[LW-9:0]};
            end
        end
    end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb_icache_fill_ctrl: directed and randomized refills checked against a transaction-level model.
module tb_icache_fill_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rdy = 1'b1;
    logic         req = 1'b0;
    logic [31:0]  block_addr = '0;
    logic         fill_valid, busy, mem_wr;
    logic [127:0] fill_data;
    logic [31:0]  mem_a;
    logic [7:0]   mem_din = '0;
    logic [7:0]   salt = '0;
    logic [127:0] last_fill = '0;
    logic [31:0]  exp_mem_a = '0;
    int           tests = 0;
    int           fails = 0;

    icache_fill_ctrl #(.ADDR_W(32), .BLOCK_BYTES(16)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .req(req), .block_addr(block_addr),
        .fill_valid(fill_valid), .fill_data(fill_data), .busy(busy),
        .mem_a(mem_a), .mem_wr(mem_wr), .mem_din(mem_din)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram(input logic [31:0] a);
        return (a[7:0] + 8'h10 + {a[9:8] - 2'd1, 6'd0}) ^ salt;
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] b);
        logic [127:0] l = '0;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = ram(b + 32'(i));
        return l;
    endfunction

    always @(posedge clk) if (rdy) mem_din <= ram(mem_a);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // k counts active edges since accept: busy for k=1..18, pulse at k=18, idle again at k=19
    task automatic fill(input logic [31:0] addr, input logic [63:0] stall, input int abort_at,
                        input int rst_at, input logic hold, input logic [31:0] next_addr);
        logic [31:0] base = addr & ~32'hF;
        int k = 0;
        int fv = -1;
        int e;
        bit ab = 0;
        bit rs = 0;
        logic exp_fv;
        block_addr = addr;
        req = 1'b1;
        for (int c = 0; c < 200 && k < 19 && !ab && !rs; c++) begin
            rdy = (c == 0) ? 1'b1 : (c < 64 ? !stall[c] : 1'b1);
            if (c == abort_at) req = 1'b0;
            if (k == 18 && hold) begin
                req = 1'b1;
                block_addr = next_addr;
            end else if (c > 0 && k < 18) block_addr = $urandom;
            if (c == rst_at) rst = 1'b0;
            @(posedge clk);
            if (!rst) rs = 1;
            else if (rdy) begin
                if (!req && k >= 1 && k <= 17) ab = 1;
                else k++;
            end
            #1;
            rst = 1'b1;
            if (rs) begin
                exp_mem_a = '0;
                last_fill = '0;
            end else if (!ab && k >= 1) exp_mem_a = base + 32'(k > 16 ? 15 : k - 1);
            exp_fv = !rs && !ab && k == 18;
            if (exp_fv) begin
                last_fill = line_of(base);
                if (fv < 0) fv = c + 1;
            end
            chk("fill_valid", 128'(fill_valid), 128'(exp_fv));
            chk("busy", 128'(busy), 128'(!rs && !ab && k >= 1 && k <= 18));
            chk("mem_a", 128'(mem_a), 128'(exp_mem_a));
            chk("fill_data", fill_data, last_fill);
            chk("mem_wr", 128'(mem_wr), 128'(0));
        end
        if (!ab && !rs) begin
            e = 18;
            for (int c = 1; c < e; c++) if (c < 64 && stall[c]) e++;
            chk("fv_cycle", 128'(fv), 128'(e));
        end
        if (!hold) req = 1'b0;
        rdy = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fill_valid", 128'(fill_valid), 128'(0));
        chk("rst_fill_data", fill_data, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_mem_a", 128'(mem_a), 128'(0));
        chk("rst_mem_wr", 128'(mem_wr), 128'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        fill(32'h10C, 64'd0, -1, -1, 1'b0, 32'd0);
        chk("line_const", fill_data, 128'h1F1E1D1C1B1A19181716151413121110);
        fill(32'h10C, (64'd1 << 5) | (64'd1 << 6) | (64'd1 << 12), -1, -1, 1'b0, 32'd0);
        chk("stall_line", fill_data, 128'h1F1E1D1C1B1A19181716151413121110);
        fill(32'h104, 64'd0, 8, -1, 1'b0, 32'd0);
        fill(32'h200, 64'd0, -1, -1, 1'b0, 32'd0);
        chk("after_abort_line", fill_data, 128'h5F5E5D5C5B5A59585756555453525150);
        fill(32'h100, 64'd0, -1, -1, 1'b1, 32'h120);
        fill(32'h120, 64'd0, -1, -1, 1'b0, 32'd0);
        fill(32'hFFFF_FFF4, 64'd0, -1, -1, 1'b0, 32'd0);
        fill(32'hFFFF_FFF4, 64'd0, -1, 10, 1'b0, 32'd0);
        for (int t = 0; t < 30; t++) begin
            salt = 8'($urandom);
            fill($urandom, {$urandom, $urandom} & {$urandom, $urandom},
                 ($urandom % 4 == 0) ? int'($urandom_range(1, 17)) : -1, -1,
                 1'($urandom % 2), $urandom);
            if (req) begin
                req = 1'b0;
                @(posedge clk);
                #1;
                req = 1'b0;
                rst = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b1;
                exp_mem_a = '0;
                last_fill = '0;
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
